// File: rtl/vend_pkg.sv
// Shared vending-machine types and constants: FSM states, coin codes and the
// coin-to-units mapping used by the credit and change logic.
package vend_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccum  = 2'b01,
    StVend   = 2'b10,
    StRefund = 2'b11
  } vend_state_e;

  typedef enum logic [1:0] {
    CoinNone = 2'b00,
    Coin1    = 2'b01,
    Coin2    = 2'b10,
    Coin5    = 2'b11
  } coin_type_e;

  localparam int unsigned DefaultPrice      = 6;
  localparam int unsigned DefaultMaxCredit  = 8;
  localparam int unsigned DefaultAckTimeout = 15;

  function automatic logic [3:0] coin_value(logic [1:0] code);
    case (coin_type_e'(code))
      Coin1:   return 4'd1;
      Coin2:   return 4'd2;
      Coin5:   return 4'd5;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_timeout_ctr.sv
// Dispenser acknowledge timeout counter: counts enabled cycles from a clear and
// flags the cycle in which the count sits at Terminal-1.
module vend_timeout_ctr #(
  parameter int unsigned Terminal = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = (Terminal > 1) ? $clog2(Terminal) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Terminal - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      // Saturate at the terminal count so a stalled enable never wraps.
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/coin_credit_fsm.sv
// Coin acceptor and credit accumulator: sums coins, requests a vend at the
// item price, and handles dispenser handshake, cancel/refund and ack timeout.
module coin_credit_fsm
  import vend_pkg::*;
#(
  parameter int unsigned Price      = DefaultPrice,
  parameter int unsigned MaxCredit  = DefaultMaxCredit,
  parameter int unsigned AckTimeout = DefaultAckTimeout
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       coin_valid_i,
  input  logic [1:0] coin_type_i,
  input  logic       cancel_i,
  input  logic       vend_ack_i,
  output logic [3:0] amount_o,
  output logic       vend_req_o,
  output logic       refund_req_o,
  output logic       coin_reject_o,
  output logic       busy_o
);

  localparam logic [4:0] Price5     = 5'(Price);
  localparam logic [4:0] MaxCredit5 = 5'(MaxCredit);

  vend_state_e state_q, state_d;
  logic [3:0]  credit_q, credit_d;
  logic        reject_q, reject_d;
  logic        vend_req_q, refund_req_q, busy_q;

  logic [4:0]  cand;
  logic        coin_ok;
  logic        tmo_tc;

  vend_timeout_ctr #(
    .Terminal (AckTimeout)
  ) u_timeout (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (state_q != StVend),
    .en_i   ((state_q == StVend) && !vend_ack_i),
    .tc_o   (tmo_tc)
  );

  // Five-bit sum so an over-limit coin cannot wrap below MaxCredit.
  assign cand    = {1'b0, credit_q} + {1'b0, coin_value(coin_type_i)};
  assign coin_ok = (coin_type_e'(coin_type_i) != CoinNone) && (cand <= MaxCredit5);

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;

    unique case (state_q)
      StIdle, StAccum: begin
        if (state_q == StAccum && cancel_i) begin
          state_d  = StRefund;
          reject_d = coin_valid_i;
        end else if (coin_valid_i) begin
          if (coin_ok) begin
            credit_d = cand[3:0];
            state_d  = (cand >= Price5) ? StVend : StAccum;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      StVend: begin
        reject_d = coin_valid_i;
        if (vend_ack_i) begin
          credit_d = '0;
          state_d  = StIdle;
        end else if (tmo_tc) begin
          state_d = StRefund;
        end
      end
      StRefund: begin
        reject_d = coin_valid_i;
        if (vend_ack_i) begin
          credit_d = '0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      credit_q     <= '0;
      reject_q     <= 1'b0;
      vend_req_q   <= 1'b0;
      refund_req_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      reject_q     <= reject_d;
      vend_req_q   <= (state_d == StVend);
      refund_req_q <= (state_d == StRefund);
      busy_q       <= (state_d == StVend) || (state_d == StRefund);
    end
  end

  assign amount_o      = credit_q;
  assign vend_req_o    = vend_req_q;
  assign refund_req_o  = refund_req_q;
  assign coin_reject_o = reject_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_coin_credit_fsm.sv
// Bench for coin_credit_fsm: directed scenarios then random traffic, all
// compared cycle by cycle against a behavioural credit/mode model.
module tb_coin_credit_fsm;

  localparam int Price      = 6;
  localparam int MaxCredit  = 8;
  localparam int AckTimeout = 15;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       coin_valid_i = 1'b0;
  logic [1:0] coin_type_i = 2'b00;
  logic       cancel_i = 1'b0;
  logic       vend_ack_i = 1'b0;
  logic [3:0] amount_o;
  logic       vend_req_o, refund_req_o, coin_reject_o, busy_o;

  coin_credit_fsm dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .coin_valid_i  (coin_valid_i),
    .coin_type_i   (coin_type_i),
    .cancel_i      (cancel_i),
    .vend_ack_i    (vend_ack_i),
    .amount_o      (amount_o),
    .vend_req_o    (vend_req_o),
    .refund_req_o  (refund_req_o),
    .coin_reject_o (coin_reject_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Model: credit in units, mode 0 = collecting, 1 = waiting for vend, 2 = refunding.
  int m_credit = 0;
  int m_mode   = 0;
  int m_vcyc   = 0;
  bit m_rej    = 0;
  int units [4] = '{0, 1, 2, 5};

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".amount"}, amount_o, 4'(m_credit));
    chk({tag, ".vend_req"}, {3'b0, vend_req_o}, {3'b0, m_mode == 1});
    chk({tag, ".refund_req"}, {3'b0, refund_req_o}, {3'b0, m_mode == 2});
    chk({tag, ".busy"}, {3'b0, busy_o}, {3'b0, m_mode != 0});
    chk({tag, ".coin_reject"}, {3'b0, coin_reject_o}, {3'b0, m_rej});
  endtask

  task automatic model_reset();
    m_credit = 0;
    m_mode   = 0;
    m_vcyc   = 0;
    m_rej    = 0;
  endtask

  task automatic model_edge(input bit cv, input int ct, input bit cn, input bit ak);
    m_rej = 0;
    case (m_mode)
      0: begin
        if (cn && m_credit > 0) begin
          m_mode = 2;
          m_rej  = cv;
        end else if (cv) begin
          if (ct == 0 || m_credit + units[ct] > MaxCredit) begin
            m_rej = 1;
          end else begin
            m_credit += units[ct];
            if (m_credit >= Price) begin
              m_mode = 1;
              m_vcyc = 0;
            end
          end
        end
      end
      1: begin
        m_rej = cv;
        if (ak) begin
          m_credit = 0;
          m_mode   = 0;
        end else begin
          m_vcyc++;
          if (m_vcyc == AckTimeout) m_mode = 2;
        end
      end
      default: begin
        m_rej = cv;
        if (ak) begin
          m_credit = 0;
          m_mode   = 0;
        end
      end
    endcase
  endtask

  task automatic step(input string tag, input bit cv, input int ct, input bit cn, input bit ak);
    coin_valid_i = cv;
    coin_type_i  = 2'(ct);
    cancel_i     = cn;
    vend_ack_i   = ak;
    @(posedge clk_i);
    model_edge(cv, ct, cn, ak);
    #1;
    check_all(tag);
  endtask

  int vend_high;

  initial begin
    // Reset state, then idle cycles with no stimulus.
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    check_all("reset_rel");
    step("idle0", 0, 0, 0, 0);
    step("idle1", 0, 0, 1, 1);

    // 5 + 2 reaches price.
    step("c5", 1, 3, 0, 0);
    chk("c5.lit_amount", amount_o, 4'd5);
    step("c2", 1, 2, 0, 0);
    chk("c2.lit_amount", amount_o, 4'd7);
    chk("c2.lit_vend", {3'b0, vend_req_o}, 4'd1);
    step("ack", 0, 0, 0, 1);
    chk("ack.lit_amount", amount_o, 4'd0);

    // Over-limit coin rejected, then exact price, then coin during vend.
    step("c5b", 1, 3, 0, 0);
    step("c5over", 1, 3, 0, 0);
    chk("c5over.lit_rej", {3'b0, coin_reject_o}, 4'd1);
    step("c1", 1, 1, 0, 0);
    chk("c1.lit_amount", amount_o, 4'd6);
    step("coin_in_vend", 1, 1, 0, 0);
    chk("coin_in_vend.lit_rej", {3'b0, coin_reject_o}, 4'd1);
    step("cancel_in_vend", 0, 0, 1, 0);
    step("ack2", 0, 0, 0, 1);

    // Invalid coin code in IDLE.
    step("c0", 1, 0, 0, 0);

    // Cancel from ACCUM, then refund ack.
    step("c2r", 1, 2, 0, 0);
    step("cancel", 0, 0, 1, 0);
    chk("cancel.lit_refund", {3'b0, refund_req_o}, 4'd1);
    chk("cancel.lit_amount", amount_o, 4'd2);
    step("refund_ack", 0, 0, 0, 1);

    // Coin and cancel in the same cycle: cancel wins.
    step("c1r", 1, 1, 0, 0);
    step("coin_cancel", 1, 3, 1, 0);
    chk("coin_cancel.lit_rej", {3'b0, coin_reject_o}, 4'd1);
    step("refund_hold", 0, 0, 0, 0);
    step("refund_ack2", 0, 0, 0, 1);

    // Timeout: vend_req high for exactly AckTimeout cycles, then refund.
    step("t5", 1, 3, 0, 0);
    step("t1", 1, 1, 0, 0);
    vend_high = 1;
    for (int i = 0; i < AckTimeout + 3 && vend_req_o; i++) begin
      step("tmo", 0, 0, 0, 0);
      if (vend_req_o) vend_high++;
    end
    chk("tmo.lit_cycles", 4'(vend_high), 4'(AckTimeout));
    chk("tmo.lit_refund", {3'b0, refund_req_o}, 4'd1);
    chk("tmo.lit_amount", amount_o, 4'd6);
    step("tmo_ack", 0, 0, 0, 1);

    // Asynchronous reset mid-VEND.
    step("r5", 1, 3, 0, 0);
    step("r1", 1, 1, 0, 0);
    step("r_hold", 0, 0, 0, 0);
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    rst_ni = 1'b1;
    step("post_rst", 1, 1, 0, 0);
    chk("post_rst.lit_amount", amount_o, 4'd1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coin_credit_fsm.md
# coin_credit_fsm

Coin acceptor and credit accumulator for the vending machine. It sits upstream of the change/seven-segment decoder and produces the 4-bit credit code that block consumes. It sums validated coin pulses, requests a vend once credit reaches the item price, and handles the dispenser handshake, customer cancel/refund, and an acknowledge timeout. All outputs are registered.

## Interface
- PRICE, 6: credit units needed to vend.
- MAX_CREDIT, 8: highest credit that may be held. A coin that would exceed it is rejected. Must be ≤ 15.
- ACK_TIMEOUT, 15: number of VEND cycles without vend_ack before the block falls back to REFUND.
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- coin_valid  input  1  one-cycle pulse: a coin is present on coin_type.
- coin_type  input  2  coin code: 00 invalid, 01 = 1 unit, 10 = 2 units, 11 = 5 units.
- cancel  input  1  level/pulse: customer requests a refund.
- vend_ack  input  1  dispenser done, for either a vend or a refund.
- amount  output  4  current credit code; drives the change decoder's A input.
- vend_req  output  1  high throughout VEND.
- refund_req  output  1  high throughout REFUND.
- coin_reject  output  1  one-cycle pulse; the coin was not credited and is returned.
- busy  output  1  high in VEND or REFUND.

## Operation
- States: IDLE, ACCUM, VEND, REFUND. Reset state is IDLE.
- Reset values: amount = 0, all other outputs = 0.
- Credit register: 4-bit unsigned.
  - Candidate value = credit + coin value.
  - The candidate is computed 5 bits wide so the sum cannot wrap before the comparison.
  - Accept the coin only if the candidate ≤ MAX_CREDIT.
- IDLE:
  - Accepted coin: load credit, go to ACCUM. If the candidate ≥ PRICE, go directly to VEND instead.
  - cancel with zero credit: ignored.
- ACCUM:
  - Accepted coin: add to credit. If the new credit ≥ PRICE, go to VEND.
  - cancel: go to REFUND.
- VEND:
  - amount is held.
  - Timeout counter starts at 0 on entry and increments every cycle that vend_ack is low.
  - vend_ack: credit is cleared and the block goes to IDLE.
  - Counter reaches ACK_TIMEOUT−1 with vend_ack still low: go to REFUND, credit held.
- REFUND:
  - refund_req is high and amount is held.
  - vend_ack: credit is cleared and the block goes to IDLE.
  - No timeout in this state.
- Rejected coin: coin_reject pulses and credit is unchanged. A coin is rejected when any of these holds:
  - coin_type = 00
  - candidate > MAX_CREDIT
  - state is VEND or REFUND
- Simultaneous coin_valid and cancel in ACCUM: cancel wins and the coin is rejected.
- cancel in VEND or REFUND: ignored.
- vend_ack outside VEND or REFUND: ignored.
- amount always equals the credit register. amount is never above MAX_CREDIT.

## Timing
- A coin sampled at edge N updates amount, coin_reject and the state at edge N. Both amount and coin_reject are visible in cycle N+1.
- vend_req rises in the cycle after the coin that makes credit reach PRICE.
- vend_ack sampled at edge M: vend_req/refund_req and amount fall to 0 in cycle M+1. There is no one-cycle overlap.
- Timeout: vend_req is high for exactly ACK_TIMEOUT cycles, and refund_req follows in the next cycle with no gap.
- reset_n asserted in any state: all outputs go to reset values immediately (asynchronously). Credit is discarded.
- Release is synchronous to clk, and IDLE is resumed.
- Back-to-back coins on consecutive cycles must all be handled, with one decision per cycle.

## Structure
- Package vend_pkg holds:
  - the state enum (IDLE, ACCUM, VEND, REFUND)
  - the coin_type codes
  - a coin_value function (code → 4-bit units)
  - the default PRICE and MAX_CREDIT constants, shared with the change decoder
- One sub-module, vend_timeout_ctr: clear, enable, and a terminal-count flag at ACK_TIMEOUT−1.
- The FSM, credit register and reject logic stay in the top module.

## Test plan
- Reset with defaults: amount = 0, vend_req = refund_req = busy = coin_reject = 0. Reset released, no coins → outputs unchanged.
- Coin 11, then coin 10:
  - amount reads 5, then 7
  - vend_req rises the cycle after the second coin
  - vend_ack → amount = 0, IDLE
- Coin 11, then coin 11:
  - second coin gets a coin_reject pulse, amount stays 5
  - coin 01 → amount = 6, vend_req = 1
  - coin during VEND → coin_reject, amount stays 6
- Coin 10, then cancel → refund_req = 1, amount = 2. vend_ack → amount = 0.
  - Also drive coin and cancel in the same cycle from ACCUM: refund is taken, coin_reject pulses.
- Reach VEND with amount = 6 and withhold vend_ack:
  - vend_req stays high for exactly 15 cycles
  - then refund_req = 1 with amount = 6
- Assert reset_n low mid-VEND: all outputs are 0 immediately. After release, a coin 01 gives amount = 1.
